// File: rtl/demux_router.sv
// Registered 1-to-NUM_CH demultiplexer with per-channel one-entry holding registers,
// broadcast, and out-of-range drop reporting. DEMUX_ROUTER_CNT_EN enables the per-channel delivery counters.
module demux_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  localparam int AW        = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [AW-1:0]                addr,
  input  logic                         bcast,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]            dout_valid,
  input  logic [NUM_CH-1:0]            dout_ready,
  output logic                         addr_err,
  output logic [NUM_CH*16-1:0]         cnt
);

  logic [NUM_CH-1:0]     free;
  logic [NUM_CH-1:0]     load;
  logic [NUM_CH-1:0]     valid_reg;
  logic [DATA_WIDTH-1:0] data_reg [NUM_CH];
  logic                  addr_ok;
  logic                  sel_free;
  logic                  xfer;
  logic                  addr_err_reg;
  logic                  addr_err_next;

  // Indices at or above NUM_CH only exist when NUM_CH is not a power of two.
  assign addr_ok = ({1'b0, addr} < (AW+1)'(NUM_CH));

  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == AW'(i)) sel_free = free[i];
    end
  end

  // Dropped words are always accepted so a bad address can never stall the producer.
  assign din_ready     = bcast ? &free : (addr_ok ? sel_free : 1'b1);
  assign xfer          = din_valid && din_ready;
  assign addr_err_next = xfer && !bcast && !addr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err_reg <= 1'b0;
    else       addr_err_reg <= addr_err_next;
  end

  assign addr_err   = addr_err_reg;
  assign dout_valid = valid_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign free[gi] = !valid_reg[gi] || dout_ready[gi];
      assign load[gi] = xfer && (bcast || (addr == AW'(gi)));

      // A load wins over a consume, so draining and refilling in one cycle keeps valid high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (load[gi]) begin
          valid_reg[gi] <= 1'b1;
          data_reg[gi]  <= din;
        end else if (valid_reg[gi] && dout_ready[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[gi];

`ifdef DEMUX_ROUTER_CNT_EN
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          cnt_reg <= '0;
        else if (valid_reg[gi] && dout_ready[gi] && (cnt_reg != 16'hFFFF))
          cnt_reg <= cnt_reg + 16'd1;
      end

      assign cnt[gi*16 +: 16] = cnt_reg;
`else
      assign cnt[gi*16 +: 16] = 16'h0000;
`endif
    end
  endgenerate

endmodule
